// File: rtl/active_list.sv
// active_list: in-order reorder tracker; rename allocates at tail, writebacks mark done, head graduates in order.
// Latency: graduation is combinational from head state; a writeback at edge t graduates in cycle t+1 at the earliest.
// Backpressure: alloc_ready_o drops only when full (no graduation bypass); a flush drops a same-cycle alloc. Option: AL_PERF_CNT_EN.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module active_list #(
    parameter int AL_SIZE = `AL_SIZE,
    parameter int NUM_WB  = 2,
    parameter int IW      = $clog2(AL_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid_i,
    input  logic [5:0]                 alloc_rd_i,
    input  logic                       alloc_uses_rd_i,
    output logic                       alloc_ready_o,
    output logic [IW-1:0]              alloc_idx_o,
    input  logic [NUM_WB-1:0]          wb_valid_i,
    input  logic [NUM_WB-1:0][IW-1:0]  wb_al_idx_i,
    input  logic                       flush_i,
    input  logic [IW-1:0]              flush_al_idx_i,
    output logic                       grad_valid_o,
    output logic [5:0]                 grad_rd_o,
    output logic                       grad_uses_rd_o,
    output logic [IW-1:0]              grad_al_idx_o,
    output logic [IW:0]                count_o,
    output logic                       empty_o
`ifdef AL_PERF_CNT_EN
    ,
    output logic [31:0]                grad_count_o,
    output logic [31:0]                squash_count_o
`endif
);

    typedef struct packed {
        logic [5:0] rd;
        logic       uses_rd;
    } entry_t;

    entry_t                     entries [AL_SIZE];
    logic [AL_SIZE-1:0]         done;
    logic [IW:0]                head, tail, count, tail_flush;
    logic [IW-1:0]              head_idx, tail_idx, flush_off;
    logic [NUM_WB-1:0][IW-1:0]  wb_off;
    logic [AL_SIZE-1:0]         wb_set, grad_clr, alloc_clr;
    logic                       full, alloc_fire, grad_fire, flush_ok;

    assign head_idx   = head[IW-1:0];
    assign tail_idx   = tail[IW-1:0];
    assign count      = tail - head;
    assign full       = (head_idx == tail_idx) && (head[IW] != tail[IW]);
    assign empty_o    = (head == tail);

    // Offsets are taken relative to head so range checks and the new tail survive pointer wrap.
    assign flush_off  = flush_al_idx_i - head_idx;
    assign flush_ok   = ({1'b0, flush_off} < count);
    assign tail_flush = head + {1'b0, flush_off} + (IW+1)'(1);

    assign alloc_ready_o = !full;
    assign alloc_fire    = alloc_valid_i && !full && !flush_i;
    assign grad_fire     = !empty_o && done[head_idx];

    assign alloc_idx_o    = tail_idx;
    assign grad_valid_o   = grad_fire;
    assign grad_rd_o      = entries[head_idx].rd;
    assign grad_uses_rd_o = entries[head_idx].uses_rd;
    assign grad_al_idx_o  = head_idx;
    assign count_o        = count;

    // Writebacks only land on live entries; in a flush cycle entries younger than the branch are dead.
    always_comb begin
        wb_set = '0;
        wb_off = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            wb_off[k] = wb_al_idx_i[k] - head_idx;
            if (wb_valid_i[k] && ({1'b0, wb_off[k]} < count) && (!flush_i || (wb_off[k] <= flush_off)))
                wb_set[wb_al_idx_i[k]] = 1'b1;
        end
    end

    assign grad_clr  = {{(AL_SIZE-1){1'b0}}, grad_fire} << head_idx;
    assign alloc_clr = {{(AL_SIZE-1){1'b0}}, alloc_fire} << tail_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            done <= '0;
        end else begin
            done <= (done | wb_set) & ~grad_clr & ~alloc_clr;
            if (grad_fire)
                head <= head + (IW+1)'(1);
            if (flush_i)
                tail <= tail_flush;
            else if (alloc_fire)
                tail <= tail + (IW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire)
            entries[tail_idx] <= '{rd: alloc_rd_i, uses_rd: alloc_uses_rd_i};
    end

`ifdef AL_PERF_CNT_EN
    logic [IW:0] squash_n;
    assign squash_n = tail - tail_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grad_count_o   <= '0;
            squash_count_o <= '0;
        end else begin
            if (grad_fire)
                grad_count_o <= grad_count_o + 32'd1;
            if (flush_i && flush_ok)
                squash_count_o <= squash_count_o + 32'(squash_n);
        end
    end
`endif

    assert property (@(posedge clk) disable iff (rst) flush_i |-> flush_ok);

endmodule
